stopwatch_ctrl: RTL and testbench

//  Control/timebase for the stopwatch. Divides clk into a display scan strobe and a 0.1 s count tick.

---
 rtl/stopwatch_ctrl_if.sv | 26 ++
 rtl/stopwatch_ctrl.sv | 125 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bus: debounced button pulses in,
// BCD digits, scan strobe and status flags out.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       scan;
    logic       running;
    logic       lap_hold;
    logic       full;

    modport master (
        output btn_ss, btn_lap,
        input  d3, d2, d1, d0,
        input  scan, running, lap_hold, full
    );

    modport slave (
        input  btn_ss, btn_lap,
        output d3, d2, d1, d0,
        output scan, running, lap_hold, full
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch timebase, start/stop/lap/clear FSM and
// 4-digit BCD time SSS.T with registered display mux.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 5_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input logic              clk,
    input logic              r,
    stopwatch_ctrl_if.slave  bus
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, RUN, LAP, PAUSE, FULL
    } state_t;

    state_t state, state_nx;

    logic [SW-1:0] scnt;
    logic [TW-1:0] tcnt;
    logic [15:0]   tm;
    logic [15:0]   lr;
    logic [15:0]   dsp;
    logic [15:0]   tm_inc;
    logic          live;
    logic          tick;
    logic          top;
    logic          clr;
    logic          cap;

    assign live = (state == RUN) || (state == LAP);
    assign tick = live && (tcnt == TMAX);
    assign top  = (tm == 16'h9998);
    assign clr  = ((state == PAUSE) || (state == FULL))
                  && (state_nx == IDLE);
    assign cap  = (state == RUN) && (state_nx == LAP);

    always_ff @(posedge clk or posedge r) begin
        if (r) state <= IDLE;
        else   state <= state_nx;
    end

    // Reaching 999.9 overrides any button in the same cycle.
    always_comb begin
        state_nx = state;
        if (tick && top) begin
            state_nx = FULL;
        end else begin
            unique case (state)
                IDLE:
                    if (bus.btn_ss) state_nx = RUN;
                RUN:
                    if (bus.btn_ss)       state_nx = PAUSE;
                    else if (bus.btn_lap) state_nx = LAP;
                LAP:
                    if (bus.btn_ss)       state_nx = PAUSE;
                    else if (bus.btn_lap) state_nx = RUN;
                PAUSE:
                    if (bus.btn_ss)       state_nx = RUN;
                    else if (bus.btn_lap) state_nx = IDLE;
                FULL:
                    if (!bus.btn_ss && bus.btn_lap)
                        state_nx = IDLE;
                default:
                    state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.running  = live;
        bus.lap_hold = (state == LAP);
        bus.full     = (state == FULL);
        bus.scan     = (scnt == SMAX);
    end

    always_comb begin
        logic c;
        tm_inc = tm;
        c      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (tm[4*i +: 4] == 4'd9) begin
                    tm_inc[4*i +: 4] = 4'd0;
                end else begin
                    tm_inc[4*i +: 4] = tm[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            scnt <= '0;
            tcnt <= '0;
            tm   <= '0;
            lr   <= '0;
            dsp  <= '0;
        end else begin
            scnt <= (scnt == SMAX) ? '0 : scnt + 1'b1;

            if (state == IDLE || clr || tick) tcnt <= '0;
            else if (live)                    tcnt <= tcnt + 1'b1;

            if (clr)       tm <= '0;
            else if (tick) tm <= tm_inc;

            if (clr)      lr <= '0;
            else if (cap) lr <= tm;

            dsp <= (state == LAP) ? lr : tm;
        end
    end

    assign bus.d3 = dsp[15:12];
    assign bus.d2 = dsp[11:8];
    assign bus.d1 = dsp[7:4];
    assign bus.d0 = dsp[3:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch bench: directed scenarios plus random presses,
// checked each cycle against a tenths-of-a-second model.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int SD = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_LAP   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_FULL  = 4;

    logic clk = 1'b0;
    logic r   = 1'b1;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .TICK_DIV (TD),
        .SCAN_DIV (SD)
    ) dut (
        .clk (clk),
        .r   (r),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: time and lap in tenths, elapsed running clocks
    int mst   = M_IDLE;
    int mt    = 0;
    int ml    = 0;
    int mph   = 0;
    int msc   = 0;
    int mdisp = 0;

    int  ns, nt, nl;
    bit  tk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or posedge r) begin
        if (r) begin
            mst = M_IDLE; mt = 0; ml = 0;
            mph = 0; msc = 0; mdisp = 0;
        end else begin
            mdisp = (mst == M_LAP) ? ml : mt;
            msc   = (msc + 1) % SD;
            tk    = 1'b0;
            if (mst == M_RUN || mst == M_LAP) begin
                mph = mph + 1;
                if (mph == TD) begin
                    mph = 0;
                    tk  = 1'b1;
                end
            end
            if (mst == M_IDLE) mph = 0;
            nt = tk ? mt + 1 : mt;
            nl = ml;
            ns = mst;
            if (tk && nt == 9999) begin
                ns = M_FULL;
            end else begin
                case (mst)
                    M_IDLE:
                        if (bus.btn_ss) ns = M_RUN;
                    M_RUN:
                        if (bus.btn_ss) ns = M_PAUSE;
                        else if (bus.btn_lap) begin
                            ns = M_LAP;
                            nl = mt;
                        end
                    M_LAP:
                        if (bus.btn_ss)       ns = M_PAUSE;
                        else if (bus.btn_lap) ns = M_RUN;
                    M_PAUSE:
                        if (bus.btn_ss) ns = M_RUN;
                        else if (bus.btn_lap) begin
                            ns = M_IDLE; nt = 0; nl = 0; mph = 0;
                        end
                    M_FULL:
                        if (!bus.btn_ss && bus.btn_lap) begin
                            ns = M_IDLE; nt = 0; nl = 0; mph = 0;
                        end
                    default: ns = M_IDLE;
                endcase
            end
            mst = ns;
            mt  = nt;
            ml  = nl;
        end
    end

    task automatic chk(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dval();
        return {bus.d3, bus.d2, bus.d1, bus.d0};
    endfunction

    always @(negedge clk) begin
        chk("m_digits", dval(), to_bcd(mdisp));
        chk("m_scan", 16'(bus.scan), 16'(msc == SD - 1));
        chk("m_running", 16'(bus.running),
            16'(mst == M_RUN || mst == M_LAP));
        chk("m_lap_hold", 16'(bus.lap_hold), 16'(mst == M_LAP));
        chk("m_full", 16'(bus.full), 16'(mst == M_FULL));
    end

    task automatic pulse_ss();
        bus.btn_ss = 1'b1;
        @(negedge clk);
        bus.btn_ss = 1'b0;
    endtask

    task automatic pulse_lap();
        bus.btn_lap = 1'b1;
        @(negedge clk);
        bus.btn_lap = 1'b0;
    endtask

    initial begin
        bit seen;
        bus.btn_ss  = 1'b0;
        bus.btn_lap = 1'b0;
        repeat (3) @(negedge clk);
        r = 1'b0;

        repeat (20) @(negedge clk);
        chk("idle_d", dval(), 16'h0000);
        chk("idle_running", 16'(bus.running), 16'h0);

        pulse_ss();
        repeat (41) @(negedge clk);
        chk("start_d", dval(), 16'h0010);
        chk("start_running", 16'(bus.running), 16'h1);

        pulse_ss();
        pulse_lap();
        @(negedge clk);
        chk("clear_d", dval(), 16'h0000);

        pulse_ss();
        repeat (20) @(negedge clk);
        pulse_lap();
        repeat (8) @(negedge clk);
        chk("lap_frozen_d", dval(), 16'h0005);
        chk("lap_hold", 16'(bus.lap_hold), 16'h1);
        pulse_lap();
        @(negedge clk);
        chk("lap_live_d", dval(), 16'h0007);

        bus.btn_ss  = 1'b1;
        bus.btn_lap = 1'b1;
        @(negedge clk);
        bus.btn_ss  = 1'b0;
        bus.btn_lap = 1'b0;
        chk("both_running", 16'(bus.running), 16'h0);
        chk("both_lap_hold", 16'(bus.lap_hold), 16'h0);
        pulse_lap();
        @(negedge clk);

        pulse_ss();
        repeat (5) @(negedge clk);
        pulse_ss();
        repeat (3) @(negedge clk);
        chk("pause_d", dval(), 16'h0001);
        pulse_ss();
        @(negedge clk);
        chk("resume_r1_d", dval(), 16'h0001);
        @(negedge clk);
        chk("resume_r2_d", dval(), 16'h0001);
        @(negedge clk);
        chk("resume_r3_d", dval(), 16'h0002);
        pulse_ss();
        pulse_lap();
        @(negedge clk);

        pulse_ss();
        repeat (493) @(negedge clk);
        chk("pre_reset_d", dval(), 16'h0123);
        #2 r = 1'b1;
        #1;
        chk("reset_d", dval(), 16'h0000);
        chk("reset_running", 16'(bus.running), 16'h0);
        chk("reset_scan", 16'(bus.scan), 16'h0);
        @(negedge clk);
        r = 1'b0;
        pulse_ss();
        repeat (5) @(negedge clk);
        chk("restart_d", dval(), 16'h0001);
        pulse_ss();
        pulse_lap();
        @(negedge clk);

        pulse_ss();
        repeat (100) @(negedge clk);
        pulse_lap();
        seen = 1'b0;
        for (int n = 0; n < 45000; n++) begin
            @(negedge clk);
            if (bus.full) begin
                seen = 1'b1;
                break;
            end
        end
        chk("full_reached", 16'(seen), 16'h1);
        @(negedge clk);
        chk("full_d", dval(), 16'h9999);
        chk("full_lap_hold", 16'(bus.lap_hold), 16'h0);
        pulse_ss();
        repeat (10) @(negedge clk);
        chk("full_hold_d", dval(), 16'h9999);
        chk("full_flag", 16'(bus.full), 16'h1);
        pulse_lap();
        @(negedge clk);
        chk("full_clear_d", dval(), 16'h0000);
        chk("full_clear_flag", 16'(bus.full), 16'h0);

        for (int i = 0; i < 3000; i++) begin
            bus.btn_ss  = ($urandom_range(0, 15) == 0);
            bus.btn_lap = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        bus.btn_ss  = 1'b0;
        bus.btn_lap = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
